mem_stage: RTL and testbench

- Pipeline memory stage directly downstream of the execute-stage ALU.
- Registers the ALU result together with its control bits (the EX/MEM register), then either forwards the result to writeback or runs a data-memory load/store over a req/ack handshake.
- Generates byte enables and replicated write data for stores, extracts and sign/zero-extends load data, flags misaligned accesses, and back-pressures execute while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage : EX/MEM register and data-memory req/ack stage (opt MEM_STAGE_TIMEOUT_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_aluout,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [3:0]            ex_memop,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_regwrite,
    output logic                  mem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_regwrite,
    output logic                  addr_exc,
    output logic                  bus_err
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    generate
        if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
            $error("mem_stage: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic [3:0]  r_memop;
    logic [1:0]  r_off;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign mem_ready = (r_state == S_IDLE);

    // Decode of the incoming op; codes 9-15 fall through as non-memory.
    always_comb begin
        w_is_load    = (ex_memop >= c_OP_LB) && (ex_memop <= c_OP_LW);
        w_is_store   = (ex_memop >= c_OP_SB) && (ex_memop <= c_OP_SW);
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = ex_store_data;
        case (ex_memop)
            c_OP_LH, c_OP_LHU: w_misaligned = ex_aluout[0];
            c_OP_LW:           w_misaligned = |ex_aluout[1:0];
            c_OP_SB: begin
                w_be    = 4'b0001 << ex_aluout[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            c_OP_SH: begin
                w_misaligned = ex_aluout[0];
                w_be         = ex_aluout[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{ex_store_data[15:0]}};
            end
            c_OP_SW:           w_misaligned = |ex_aluout[1:0];
            default: ;
        endcase
    end

    // Little-endian lane extraction of the returned word.
    always_comb begin
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_off)
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            2'd3:    w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        case (r_memop)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'd0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = dmem_rdata;
        endcase
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_tmo_cnt;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd        <= 5'd0;
            r_regwrite  <= 1'b0;
            r_memop     <= 4'd0;
            r_off       <= 2'd0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'd0;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= 5'd0;
            wb_regwrite <= 1'b0;
            addr_exc    <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            bus_err     <= 1'b0;
            r_tmo_cnt   <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
            addr_exc <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!(w_is_load || w_is_store)) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= ex_aluout;
                            wb_rd       <= ex_rd;
                            wb_regwrite <= ex_regwrite & (ex_rd != 5'd0);
                        end else if (w_misaligned) begin
                            addr_exc <= 1'b1;
                        end else begin
                            r_state    <= S_WAIT;
                            dmem_req   <= 1'b1;
                            dmem_we    <= w_is_store;
                            dmem_addr  <= {ex_aluout[31:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata;
                            r_rd       <= ex_rd;
                            r_regwrite <= ex_regwrite & (ex_rd != 5'd0) & w_is_load;
                            r_memop    <= ex_memop;
                            r_off      <= ex_aluout[1:0];
`ifdef MEM_STAGE_TIMEOUT_EN
                            r_tmo_cnt  <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        r_state     <= S_IDLE;
                        dmem_req    <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_data     <= w_load_data;
                        wb_rd       <= r_rd;
                        wb_regwrite <= r_regwrite;
                    end
`ifdef MEM_STAGE_TIMEOUT_EN
                    else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state  <= S_IDLE;
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Testbench for mem_stage: directed vector table, hand sequences and random ops vs. a reference model.
module tb_mem_stage;

    localparam int TB_TMO = 4;

    logic        clk, rst_n, ex_valid, ex_regwrite, dmem_ack;
    logic [31:0] ex_aluout, ex_store_data, dmem_rdata;
    logic [3:0]  ex_memop;
    logic [4:0]  ex_rd;
    logic        mem_ready, dmem_req, dmem_we, wb_valid, wb_regwrite, addr_exc, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_aluout(ex_aluout),
        .ex_store_data(ex_store_data), .ex_memop(ex_memop), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .mem_ready(mem_ready), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .addr_exc(addr_exc), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (arithmetic view of the rules) ----------------
    function automatic bit m_is_load(input logic [3:0] op);
        return (op >= 1) && (op <= 5);
    endfunction
    function automatic bit m_is_store(input logic [3:0] op);
        return (op >= 6) && (op <= 8);
    endfunction
    function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
        if (op == 3 || op == 4 || op == 7) return (a % 2) != 0;
        if (op == 5 || op == 8)            return (a % 4) != 0;
        return 1'b0;
    endfunction
    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
        int unsigned off = a % 4;
        int unsigned b = (w >> (8 * off)) % 256;
        int unsigned h = (w >> (16 * (off / 2))) % 65536;
        case (op)
            4'd1:    return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            4'd2:    return 32'(b);
            4'd3:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            4'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction
    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int unsigned off = a % 4;
        if (op == 6) return 4'(1 << off);
        if (op == 7) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction
    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
        if (op == 6) return (sd % 256) * 32'h0101_0101;
        if (op == 7) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    // ---------------- one accepted operation, checked cycle by cycle ----------------
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input logic rw, input int dly, input logic [31:0] rdata,
                          input logic [31:0] xd, input logic xrw, input logic [3:0] xbe, input logic [31:0] xwd);
        int rdy_low;
        chk({nm, " ready_before"}, 32'(mem_ready), 32'd1);
        ex_valid = 1'b1; ex_memop = op; ex_aluout = a; ex_store_data = sd; ex_rd = rd; ex_regwrite = rw;
        @(negedge clk);
        ex_valid = 1'b0;
        if (!m_is_load(op) && !m_is_store(op)) begin
            chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
            chk({nm, " wb_data"}, wb_data, xd);
            chk({nm, " wb_rd"}, 32'(wb_rd), 32'(rd));
            chk({nm, " wb_regwrite"}, 32'(wb_regwrite), 32'(xrw));
            chk({nm, " no_exc"}, {30'd0, addr_exc, bus_err}, 32'd0);
            chk({nm, " no_req"}, 32'(dmem_req), 32'd0);
        end else if (m_misal(op, a)) begin
            chk({nm, " addr_exc"}, 32'(addr_exc), 32'd1);
            chk({nm, " no_wb"}, 32'(wb_valid), 32'd0);
            chk({nm, " no_req"}, 32'(dmem_req), 32'd0);
            chk({nm, " ready"}, 32'(mem_ready), 32'd1);
        end else begin
            chk({nm, " req"}, 32'(dmem_req), 32'd1);
            chk({nm, " we"}, 32'(dmem_we), 32'(m_is_store(op)));
            chk({nm, " addr"}, dmem_addr, a - (a % 4));
            chk({nm, " no_exc"}, 32'(addr_exc), 32'd0);
            if (m_is_store(op)) begin
                chk({nm, " be"}, 32'(dmem_be), 32'(xbe));
                chk({nm, " wdata"}, dmem_wdata, xwd);
            end
            rdy_low = 0;
            for (int k = 0; k < dly; k++) begin
                if (!mem_ready) rdy_low++;
                chk({nm, " hold_addr"}, dmem_addr, a - (a % 4));
                @(negedge clk);
            end
            if (!mem_ready) rdy_low++;
            chk({nm, " req_at_ack"}, 32'(dmem_req), 32'd1);
            dmem_ack = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
            chk({nm, " wb_rd"}, 32'(wb_rd), 32'(rd));
            chk({nm, " wb_regwrite"}, 32'(wb_regwrite), 32'(xrw));
            if (m_is_load(op)) chk({nm, " wb_data"}, wb_data, xd);
            chk({nm, " req_drop"}, 32'(dmem_req), 32'd0);
            chk({nm, " ready_after"}, 32'(mem_ready), 32'd1);
            chk({nm, " stall_cycles"}, 32'(rdy_low), 32'(dly + 1));
        end
    endtask

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a, sd;
        logic [4:0]  rd;
        logic        rw;
        int          dly;
        logic [31:0] rdata, xd;
        logic        xrw;
        logic [3:0]  xbe;
        logic [31:0] xwd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input int dly, input logic [31:0] rdata,
                       input logic [31:0] xd, input logic xrw, input logic [3:0] xbe, input logic [31:0] xwd);
        vec_t v;
        v.nm = nm; v.op = op; v.a = a; v.sd = sd; v.rd = rd; v.rw = rw; v.dly = dly;
        v.rdata = rdata; v.xd = xd; v.xrw = xrw; v.xbe = xbe; v.xwd = xwd;
        tv.push_back(v);
    endtask

    initial begin
        int first_err;
        bit saw_wb;
        logic [3:0]  op;
        logic [31:0] a, sd, rdata;
        logic [4:0]  rd;
        logic        rw;

        rst_n = 1'b0; ex_valid = 1'b0; ex_aluout = '0; ex_store_data = '0; ex_memop = '0;
        ex_rd = '0; ex_regwrite = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;

        add("none",   4'd0,  32'h0000_0011, 32'h0,         5'd5, 1'b1, 0, 32'h0,         32'h0000_0011, 1'b1, 4'h0, 32'h0);
        add("lb",     4'd1,  32'h0000_0103, 32'h0,         5'd3, 1'b1, 2, 32'h80FF_1234, 32'hFFFF_FF80, 1'b1, 4'h0, 32'h0);
        add("lhu",    4'd4,  32'h0000_0102, 32'h0,         5'd4, 1'b1, 0, 32'h8001_0000, 32'h0000_8001, 1'b1, 4'h0, 32'h0);
        add("lh",     4'd3,  32'h0000_0102, 32'h0,         5'd4, 1'b1, 1, 32'h8001_0000, 32'hFFFF_8001, 1'b1, 4'h0, 32'h0);
        add("sh",     4'd7,  32'h0000_0202, 32'h1234_ABCD, 5'd6, 1'b1, 1, 32'h0,         32'h0,         1'b0, 4'hC, 32'hABCD_ABCD);
        add("lw_rd0", 4'd5,  32'h0000_0300, 32'h0,         5'd0, 1'b1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0);
        add("sb",     4'd6,  32'h0000_0401, 32'h0000_00A5, 5'd7, 1'b0, 0, 32'h0,         32'h0,         1'b0, 4'h2, 32'hA5A5_A5A5);
        add("sw",     4'd8,  32'h0000_0500, 32'hCAFE_F00D, 5'd8, 1'b1, 2, 32'h0,         32'h0,         1'b0, 4'hF, 32'hCAFE_F00D);
        add("lw_mis", 4'd5,  32'h0000_0101, 32'h0,         5'd9, 1'b1, 0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0);
        add("lbu",    4'd2,  32'h0000_0101, 32'h0,         5'd9, 1'b1, 0, 32'h1234_F600, 32'h0000_00F6, 1'b1, 4'h0, 32'h0);
        add("op12",   4'd12, 32'h0000_0077, 32'h0,         5'd9, 1'b1, 0, 32'h0,         32'h0000_0077, 1'b1, 4'h0, 32'h0);

        repeat (2) @(negedge clk);
        chk("reset ready", 32'(mem_ready), 32'd1);
        chk("reset req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
        chk("reset addr", dmem_addr, 32'd0);
        chk("reset wb", {25'd0, wb_valid, wb_regwrite, wb_rd}, 32'd0);
        chk("reset flags", {30'd0, addr_exc, bus_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back non-memory accepts
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1; ex_memop = 4'd0; ex_aluout = 32'h11 + 32'(i); ex_rd = 5'd5; ex_regwrite = 1'b1;
            @(negedge clk);
            chk("b2b wb_valid", 32'(wb_valid), 32'd1);
            chk("b2b wb_data", wb_data, 32'h11 + 32'(i));
            chk("b2b ready", 32'(mem_ready), 32'd1);
        end
        ex_valid = 1'b0;
        @(negedge clk);
        chk("b2b pulse_end", 32'(wb_valid), 32'd0);

        // ack with no outstanding request
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stray_ack wb", 32'(wb_valid), 32'd0);
        chk("stray_ack ready", 32'(mem_ready), 32'd1);

        foreach (tv[i])
            run_op(tv[i].nm, tv[i].op, tv[i].a, tv[i].sd, tv[i].rd, tv[i].rw, tv[i].dly,
                   tv[i].rdata, tv[i].xd, tv[i].xrw, tv[i].xbe, tv[i].xwd);

        // reset while waiting for ack
        ex_valid = 1'b1; ex_memop = 4'd5; ex_aluout = 32'h600; ex_rd = 5'd2; ex_regwrite = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstwait req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwait req_drop", 32'(dmem_req), 32'd0);
        chk("rstwait ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstwait after", {30'd0, mem_ready, wb_valid}, 32'd2);

`ifdef MEM_STAGE_TIMEOUT_EN
        ex_valid = 1'b1; ex_memop = 4'd5; ex_aluout = 32'h700; ex_rd = 5'd2; ex_regwrite = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        first_err = 0; saw_wb = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus_err && first_err == 0) first_err = c;
            if (wb_valid) saw_wb = 1'b1;
            @(negedge clk);
        end
        chk("timeout bus_err_cycle", 32'(first_err), 32'(TB_TMO + 1));
        chk("timeout no_wb", 32'(saw_wb), 32'd0);
        chk("timeout idle", {30'd0, mem_ready, dmem_req}, 32'd2);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack ignored", 32'(wb_valid), 32'd0);
`else
        first_err = 0; saw_wb = 1'b0;
`endif

        // random ops against the model
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = (op == 5 || op == 8) ? a - (a % 4) :
                                                (op == 3 || op == 4 || op == 7) ? a - (a % 2) : a;
            sd = $urandom; rdata = $urandom;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rw = 1'($urandom);
            run_op("rand", op, a, sd, rd, rw, int'($urandom_range(0, 3)), rdata,
                   m_is_load(op) ? m_load(op, a, rdata) : a,
                   m_is_store(op) ? 1'b0 : (rw && rd != 0),
                   m_be(op, a), m_wdata(op, sd));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
